// File: rtl/adder_32_bit.sv
// Registered 32-bit two's-complement adder (A + B + carryin) with signed-overflow flag.
// Latency: 1 cycle, inputs sampled on rising clk, result held until the next edge.
// Backpressure: none. One addition accepted every cycle, no handshake.
//
// Ports:
//   clk       - clock, rising-edge active
//   rst_n     - asynchronous active-low reset, clears output1/overflow
//   input1    - operand A [31:0]
//   input2    - operand B [31:0]
//   carryin   - carry into bit 0
//   output1   - registered sum [31:0], modulo 2^32
//   overflow  - registered signed overflow (carry into bit 31 XOR carry out of bit 31)

// 4-bit carry-lookahead group: all internal carries come straight from g/p terms
// and the group carry-in, so each group costs one lookahead delay in the chain.
module adder_32_bit_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;
   logic       grp_g;
   logic       grp_p;

   always_comb begin
      g = a & b;
      p = a ^ b;

      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

      // Group generate/propagate let the group carry-out skip the internal bits.
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;

      cout = grp_g | (grp_p & cin);
      sum  = p ^ c;
   end

endmodule

module adder_32_bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] input1,
   input  logic [31:0] input2,
   input  logic        carryin,
   output logic [31:0] output1,
   output logic        overflow
);

   // grp_carry[i] is the carry into group i; grp_carry[8] is the carry out of bit 31.
   logic [8:0]  grp_carry;
   logic [31:0] sum_next;
   logic        c31;
   logic        c32;
   logic        overflow_next;

   assign grp_carry[0] = carryin;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_grp
         adder_32_bit_cla4 u_cla4 (
            .a    (input1[4*gi +: 4]),
            .b    (input2[4*gi +: 4]),
            .cin  (grp_carry[gi]),
            .sum  (sum_next[4*gi +: 4]),
            .cout (grp_carry[gi+1])
         );
      end
   endgenerate

   // Sum bit 31 is a31 ^ b31 ^ c31, so the carry into bit 31 falls out of it
   // without exporting internal carries from the top group.
   always_comb begin
      c32           = grp_carry[8];
      c31           = sum_next[31] ^ input1[31] ^ input2[31];
      overflow_next = c31 ^ c32;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         output1  <= 32'h0000_0000;
         overflow <= 1'b0;
      end else begin
         output1  <= sum_next;
         overflow <= overflow_next;
      end
   end

endmodule

// File: tb/tb_adder_32_bit.sv
module tb_adder_32_bit;

   logic        clk;
   logic        rst_n;
   logic [31:0] input1;
   logic [31:0] input2;
   logic        carryin;
   logic [31:0] output1;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   adder_32_bit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .input1   (input1),
      .input2   (input2),
      .carryin  (carryin),
      .output1  (output1),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact integer arithmetic, then truncate / range-check.
   function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input logic c);
      longint unsigned s;
      s = longint'(a) + longint'(b) + longint'(c);
      return s[31:0];
   endfunction

   function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic c);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   task automatic check(input string tag, input logic [31:0] exp_sum, input logic exp_ovf);
      checks++;
      assert (output1 === exp_sum) else begin
         errors++;
         $error("FAIL %s output1: got %h expected %h", tag, output1, exp_sum);
      end
      checks++;
      assert (overflow === exp_ovf) else begin
         errors++;
         $error("FAIL %s overflow: got %b expected %b", tag, overflow, exp_ovf);
      end
   endtask

   // Drive on the falling edge, capture on the rising edge, sample 1 time unit later.
   task automatic add_step(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c);
      @(negedge clk);
      input1  = a;
      input2  = b;
      carryin = c;
      @(posedge clk);
      #1;
      check(tag, ref_sum(a, b, c), ref_ovf(a, b, c));
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;

      rst_n   = 1'b0;
      input1  = 32'h1234_5678;
      input2  = 32'h9abc_def0;
      carryin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", 32'h0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases with hand-derived expectations.
      @(negedge clk); input1 = 32'd1; input2 = 32'd3; carryin = 1'b0;
      @(posedge clk); #1; check("basic", 32'd4, 1'b0);
      @(negedge clk); carryin = 1'b1;
      @(posedge clk); #1; check("carry_in", 32'd5, 1'b0);
      @(negedge clk); input1 = 32'h7FFF_FFFF; input2 = 32'd1; carryin = 1'b0;
      @(posedge clk); #1; check("pos_ovf", 32'h8000_0000, 1'b1);
      @(negedge clk); input1 = 32'hFFFF_FFFF; input2 = 32'd0; carryin = 1'b1;
      @(posedge clk); #1; check("uwrap", 32'h0, 1'b0);
      @(negedge clk); input1 = 32'd0; input2 = 32'd0; carryin = 1'b1;
      @(posedge clk); #1; check("cin_only", 32'd1, 1'b0);
      @(negedge clk); input1 = 32'h7FFF_FFFF; input2 = 32'h0; carryin = 1'b1;
      @(posedge clk); #1; check("cin_pos_ovf", 32'h8000_0000, 1'b1);

      // Inputs moving between edges must not reach the outputs.
      #1; input1 = 32'h0000_00AA; input2 = 32'h0000_0055; carryin = 1'b0;
      #1; check("hold_between_edges", 32'h8000_0000, 1'b1);

      // Negative overflow, then async reset asserted mid-cycle.
      @(negedge clk); input1 = 32'h8000_0000; input2 = 32'h8000_0000; carryin = 1'b0;
      @(posedge clk); #1; check("neg_ovf", 32'h0, 1'b1);
      #2; rst_n = 1'b0;
      #1; check("async_reset", 32'h0, 1'b0);
      @(posedge clk); #1; check("reset_held_edge", 32'h0, 1'b0);
      @(negedge clk); rst_n = 1'b1; input1 = 32'd10; input2 = 32'd20; carryin = 1'b0;
      @(posedge clk); #1; check("after_reset", 32'd30, 1'b0);

      // Carry chain boundaries crossing every 4-bit group.
      add_step("chain_full", 32'h0FFF_FFFF, 32'h0000_0000, 1'b1);
      add_step("chain_alt",  32'h5555_5555, 32'hAAAA_AAAA, 1'b1);
      add_step("neg_min",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      add_step("neg_min_c",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 300; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         if (i % 4 == 1) rb = ~ra;
         if (i % 4 == 2) ra = {ra[31], {31{~ra[31]}}};
         add_step("random", ra, rb, rc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
